sccb_responder: RTL and testbench

SCCB/I2C responder (slave) modelling the OV7670 register port. It is the far end of the camera configuration path: it receives the three-phase write cycles that the LUT-driven SCCB master produces, stores them in a 256×8 register file, and answers two-phase read cycles. It serves as an on-FPGA loopback target and simulation model for bring-up and for checking the configuration sequence without a sensor attached.

---
 rtl/sccb_pkg.sv | 47 ++++
 rtl/sccb_if.sv | 20 ++
 rtl/sccb_line_sync.sv | 29 ++
 rtl/sccb_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_sccb_responder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sccb_pkg.sv
// Shared types, constants and helpers for the SCCB register-port responder.
// Holds the protocol state enum, the device/ID constants and register-file policy functions.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV_ADDR  = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_REG_ADDR  = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WR_DATA   = 4'd5,
    ST_WR_ACK    = 4'd6,
    ST_RD_DATA   = 4'd7,
    ST_RD_ACK    = 4'd8,
    ST_WAIT_STOP = 4'd9
  } sccb_state_e;

  localparam logic [6:0] DEV_ID_DEFAULT = 7'h21;

  localparam logic [7:0] PID_ADDR  = 8'h0A;
  localparam logic [7:0] VER_ADDR  = 8'h0B;
  localparam logic [7:0] MIDH_ADDR = 8'h1C;
  localparam logic [7:0] MIDL_ADDR = 8'h1D;

  localparam logic [7:0] PID_DEFAULT  = 8'h76;
  localparam logic [7:0] VER_DEFAULT  = 8'h73;
  localparam logic [7:0] MIDH_DEFAULT = 8'h7F;
  localparam logic [7:0] MIDL_DEFAULT = 8'hA2;

  function automatic logic is_read_only(input logic [7:0] addr);
    return (addr == PID_ADDR) || (addr == VER_ADDR) ||
           (addr == MIDH_ADDR) || (addr == MIDL_ADDR);
  endfunction

  function automatic logic [7:0] reg_default(input logic [7:0] addr);
    logic [7:0] val;
    case (addr)
      PID_ADDR:  val = PID_DEFAULT;
      VER_ADDR:  val = VER_DEFAULT;
      MIDH_ADDR: val = MIDH_DEFAULT;
      MIDL_ADDR: val = MIDL_DEFAULT;
      default:   val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/sccb_if.sv
// SCCB pin bundle plus the write-commit observation port of the responder.
interface sccb_if;
  logic       sio_c;
  logic       sio_d_i;
  logic       sio_d_oe;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport master (
    output sio_c, sio_d_i,
    input  sio_d_oe, wr_valid, wr_addr, wr_data, busy
  );

  modport slave (
    input  sio_c, sio_d_i,
    output sio_d_oe, wr_valid, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/sccb_line_sync.sv
// Two-flop synchronizer with rise/fall detection for one asynchronous SCCB line.
module sccb_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_r;
  logic       prev_r;

  // Synchronizer chain and previous-level register; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[0], line};
      prev_r <= sync_r[1];
    end
  end

  assign level = sync_r[1];
  assign rise  = sync_r[1] & ~prev_r;
  assign fall  = ~sync_r[1] & prev_r;

endmodule

// File: rtl/sccb_responder.sv
// OV7670-style SCCB responder: 256x8 register file with auto-increment writes and reads.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ID = DEV_ID_DEFAULT
) (
  input logic   clk,
  input logic   rst_n,
  sccb_if.slave bus
);

  logic scl_lvl_s, scl_rise_s, scl_fall_s;
  logic sda_lvl_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s, rx_state_s, rx_step_s, byte_done_s;
  logic [7:0] rx_byte_s, rd_byte_s;

  sccb_state_e state_r, state_n;
  logic [3:0]  bit_cnt_r, bit_cnt_n;
  logic [7:0]  shift_r, shift_n;
  logic [7:0]  ptr_r, ptr_n;
  logic [6:0]  tx_r, tx_n;
  logic        oe_r, oe_n;
  logic        busy_r, busy_n;
  logic        rw_r, rw_n;
  logic        ack_r, ack_n;
  logic        wr_valid_r, wr_valid_n;
  logic [7:0]  wr_addr_r, wr_addr_n;
  logic [7:0]  wr_data_r, wr_data_n;
  logic        reg_we_s;
  logic [7:0]  regfile_r [256];

  sccb_line_sync u_scl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (bus.sio_c),
    .level (scl_lvl_s),
    .rise  (scl_rise_s),
    .fall  (scl_fall_s)
  );

  sccb_line_sync u_sda_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (bus.sio_d_i),
    .level (sda_lvl_s),
    .rise  (sda_rise_s),
    .fall  (sda_fall_s)
  );

  assign start_s     = sda_fall_s & scl_lvl_s;
  assign stop_s      = sda_rise_s & scl_lvl_s;
  assign rx_state_s  = state_r inside {ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA};
  assign rx_step_s   = scl_rise_s && (bit_cnt_r != 4'd8);
  assign byte_done_s = scl_fall_s && (bit_cnt_r == 4'd8);
  assign rx_byte_s   = {shift_r[6:0], sda_lvl_s};
  assign rd_byte_s   = regfile_r[ptr_r];

  // Protocol state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'h00;
      ptr_r      <= 8'h00;
      tx_r       <= 7'h00;
      oe_r       <= 1'b0;
      busy_r     <= 1'b0;
      rw_r       <= 1'b0;
      ack_r      <= 1'b1;
      wr_valid_r <= 1'b0;
      wr_addr_r  <= 8'h00;
      wr_data_r  <= 8'h00;
    end else begin
      state_r    <= state_n;
      bit_cnt_r  <= bit_cnt_n;
      shift_r    <= shift_n;
      ptr_r      <= ptr_n;
      tx_r       <= tx_n;
      oe_r       <= oe_n;
      busy_r     <= busy_n;
      rw_r       <= rw_n;
      ack_r      <= ack_n;
      wr_valid_r <= wr_valid_n;
      wr_addr_r  <= wr_addr_n;
      wr_data_r  <= wr_data_n;
    end
  end

  // Next-state and output decode; START/STOP pre-empt any SCL edge in the same cycle.
  always_comb begin
    state_n    = state_r;
    bit_cnt_n  = bit_cnt_r;
    shift_n    = shift_r;
    ptr_n      = ptr_r;
    tx_n       = tx_r;
    oe_n       = oe_r;
    busy_n     = busy_r;
    rw_n       = rw_r;
    ack_n      = ack_r;
    wr_valid_n = 1'b0;
    wr_addr_n  = wr_addr_r;
    wr_data_n  = wr_data_r;
    reg_we_s   = 1'b0;

    if (start_s) begin
      state_n   = ST_DEV_ADDR;
      bit_cnt_n = 4'd0;
      busy_n    = 1'b1;
    end else if (stop_s) begin
      state_n   = ST_IDLE;
      bit_cnt_n = 4'd0;
      oe_n      = 1'b0;
      busy_n    = 1'b0;
    end else begin
      if (rx_state_s && rx_step_s) begin
        shift_n   = rx_byte_s;
        bit_cnt_n = bit_cnt_r + 4'd1;
        // The 8th data bit commits the write; read-only targets still advance the pointer.
        if ((state_r == ST_WR_DATA) && (bit_cnt_r == 4'd7)) begin
          ptr_n = ptr_r + 8'd1;
          if (!is_read_only(ptr_r)) begin
            reg_we_s   = 1'b1;
            wr_valid_n = 1'b1;
            wr_addr_n  = ptr_r;
            wr_data_n  = rx_byte_s;
          end else begin
            reg_we_s = 1'b0;
          end
        end else begin
          reg_we_s = 1'b0;
        end
      end else begin
        reg_we_s = 1'b0;
      end

      case (state_r)
        ST_DEV_ADDR: begin
          if (byte_done_s) begin
            bit_cnt_n = 4'd0;
            if (shift_r[7:1] == DEV_ID) begin
              state_n = ST_DEV_ACK;
              oe_n    = 1'b1;
              rw_n    = shift_r[0];
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end else begin
            state_n = ST_DEV_ADDR;
          end
        end
        ST_REG_ADDR: begin
          if (byte_done_s) begin
            bit_cnt_n = 4'd0;
            ptr_n     = shift_r;
            state_n   = ST_REG_ACK;
            oe_n      = 1'b1;
          end else begin
            state_n = ST_REG_ADDR;
          end
        end
        ST_WR_DATA: begin
          if (byte_done_s) begin
            bit_cnt_n = 4'd0;
            state_n   = ST_WR_ACK;
            oe_n      = 1'b1;
          end else begin
            state_n = ST_WR_DATA;
          end
        end
        ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
          if (scl_fall_s) begin
            bit_cnt_n = 4'd0;
            oe_n      = 1'b0;
            if ((state_r == ST_DEV_ACK) && rw_r) begin
              state_n = ST_RD_DATA;
              tx_n    = rd_byte_s[6:0];
              oe_n    = ~rd_byte_s[7];
            end else if (state_r == ST_DEV_ACK) begin
              state_n = ST_REG_ADDR;
            end else begin
              state_n = ST_WR_DATA;
            end
          end else begin
            state_n = state_r;
          end
        end
        ST_RD_DATA: begin
          if (rx_step_s) begin
            bit_cnt_n = bit_cnt_r + 4'd1;
          end else if (byte_done_s) begin
            bit_cnt_n = 4'd0;
            oe_n      = 1'b0;
            ptr_n     = ptr_r + 8'd1;
            state_n   = ST_RD_ACK;
          end else if (scl_fall_s) begin
            oe_n = ~tx_r[6];
            tx_n = {tx_r[5:0], 1'b0};
          end else begin
            state_n = ST_RD_DATA;
          end
        end
        ST_RD_ACK: begin
          if (scl_rise_s) begin
            ack_n = sda_lvl_s;
          end else if (scl_fall_s && !ack_r) begin
            state_n = ST_RD_DATA;
            tx_n    = rd_byte_s[6:0];
            oe_n    = ~rd_byte_s[7];
          end else if (scl_fall_s) begin
            state_n = ST_WAIT_STOP;
            oe_n    = 1'b0;
          end else begin
            state_n = ST_RD_ACK;
          end
        end
        ST_IDLE, ST_WAIT_STOP: begin
          state_n = state_r;
        end
        default: begin
          state_n = ST_IDLE;
          oe_n    = 1'b0;
        end
      endcase
    end
  end

  // Register file with ID defaults restored on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        regfile_r[i] <= reg_default(8'(i));
      end
    end else if (reg_we_s) begin
      regfile_r[ptr_r] <= rx_byte_s;
    end
  end

  assign bus.sio_d_oe = oe_r;
  assign bus.wr_valid = wr_valid_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: bit-level SCCB master plus a transaction-level register model.
module tb_sccb_responder;

  localparam int H = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_mem [256];
  logic [7:0]  m_ptr;
  logic [15:0] exp_q [$];
  int          commits_exp = 0;
  int          commits_seen = 0;
  logic        oe_seen = 1'b0;
  logic        oe_prev;
  logic [7:0]  last_rd;

  always #5 clk = ~clk;

  sccb_if bus();
  assign bus.sio_c   = m_scl;
  assign bus.sio_d_i = m_sda & ~bus.sio_d_oe;

  sccb_responder #(.DEV_ID(7'h21)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic waitc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic m_is_ro(input logic [7:0] a);
    return (a == 8'h0A) || (a == 8'h0B) || (a == 8'h1C) || (a == 8'h1D);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_mem[8'h0A] = 8'h76;
    m_mem[8'h0B] = 8'h73;
    m_mem[8'h1C] = 8'h7F;
    m_mem[8'h1D] = 8'hA2;
    m_ptr = 8'h00;
  endtask

  task automatic bus_start();
    waitc(H/2); m_sda = 1'b1;
    waitc(H/2); m_scl = 1'b1;
    waitc(H/2); m_sda = 1'b0;
    waitc(H/2); m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    waitc(H/2); m_sda = 1'b0;
    waitc(H/2); m_scl = 1'b1;
    waitc(H/2); m_sda = 1'b1;
    waitc(H);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) begin
      waitc(H/2); m_sda = b[i];
      waitc(H/2); m_scl = 1'b1;
      waitc(H);   m_scl = 1'b0;
    end
    waitc(H/2); m_sda = 1'b1;
    waitc(H/2); m_scl = 1'b1;
    waitc(H/2); acked = (bus.sio_d_i == 1'b0);
    waitc(H/2); m_scl = 1'b0;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      waitc(H);   m_scl = 1'b1;
      waitc(H/2); b[i] = bus.sio_d_i;
      waitc(H/2); m_scl = 1'b0;
    end
    waitc(H/2); m_sda = nack;
    waitc(H/2); m_scl = 1'b1;
    waitc(H);   m_scl = 1'b0;
    waitc(2);   m_sda = 1'b1;
  endtask

  task automatic wr_txn(input logic [7:0] dev, input logic [7:0] ra, input int n,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input logic do_stop);
    logic       a;
    logic       match;
    logic [7:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    match = (dev[7:1] == 7'h21) && !dev[0];
    bus_start();
    send_byte(dev, a);
    chk("dev_ack", a, match);
    chk("busy_in_txn", bus.busy, 1'b1);
    if (match) m_ptr = ra;
    send_byte(ra, a);
    chk("reg_ack", a, match);
    for (int i = 0; i < n; i++) begin
      if (match) begin
        if (!m_is_ro(m_ptr)) begin
          m_mem[m_ptr] = d[i];
          exp_q.push_back({m_ptr, d[i]});
          commits_exp++;
        end
        m_ptr = m_ptr + 8'd1;
      end
      send_byte(d[i], a);
      chk("data_ack", a, match);
    end
    if (do_stop) begin
      bus_stop();
      chk("busy_after_stop", bus.busy, 1'b0);
    end
  endtask

  task automatic rd_txn(input int n, output logic [7:0] last);
    logic       a;
    logic [7:0] b;
    logic [7:0] e;
    bus_start();
    send_byte(8'h43, a);
    chk("rd_dev_ack", a, 1'b1);
    last = 8'h00;
    for (int i = 0; i < n; i++) begin
      e = m_mem[m_ptr];
      m_ptr = m_ptr + 8'd1;
      recv_byte(i == n - 1, b);
      chk("rd_data", b, e);
      last = b;
    end
    bus_stop();
    chk("busy_after_rd", bus.busy, 1'b0);
  endtask

  // Commit scoreboard and open-drain timing monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_valid) begin
        commits_seen++;
        chk("commit_expected", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) chk("commit", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
      end
      if (bus.sio_d_oe !== oe_prev) chk("oe_change_scl_low", m_scl, 1'b0);
      if (bus.sio_d_oe) oe_seen = 1'b1;
    end
    oe_prev = bus.sio_d_oe;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    logic       a;
    logic [7:0] cur;
    logic       exp_oe;
    m_reset();
    waitc(4);
    chk("rst_oe", bus.sio_d_oe, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_wr_valid", bus.wr_valid, 1'b0);
    rst_n = 1'b1;
    waitc(5);
    chk("rst_wr_addr", bus.wr_addr, 8'h00);
    chk("rst_wr_data", bus.wr_data, 8'h00);

    // Single write
    wr_txn(8'h42, 8'h12, 1, 8'h04, 8'h00, 8'h00, 1'b1);
    chk("wr_addr_lit", bus.wr_addr, 8'h12);
    chk("wr_data_lit", bus.wr_data, 8'h04);

    // ID reads with pointer auto-increment between reads
    wr_txn(8'h42, 8'h1C, 0, 8'h00, 8'h00, 8'h00, 1'b1);
    rd_txn(1, last_rd);
    chk("midh_lit", last_rd, 8'h7F);
    rd_txn(1, last_rd);
    chk("midl_lit", last_rd, 8'hA2);

    // Wrong device address
    oe_seen = 1'b0;
    wr_txn(8'h60, 8'h12, 1, 8'h55, 8'h00, 8'h00, 1'b1);
    chk("wrong_addr_oe_quiet", oe_seen, 1'b0);
    wr_txn(8'h42, 8'h12, 0, 8'h00, 8'h00, 8'h00, 1'b1);
    rd_txn(1, last_rd);
    chk("reg12_kept_lit", last_rd, 8'h04);

    // Burst with pointer wrap, readback through a repeated start
    wr_txn(8'h42, 8'hFE, 3, 8'h11, 8'h22, 8'h33, 1'b1);
    chk("burst_wr_addr_lit", bus.wr_addr, 8'h00);
    wr_txn(8'h42, 8'hFE, 0, 8'h00, 8'h00, 8'h00, 1'b0);
    rd_txn(3, last_rd);
    chk("burst_last_lit", last_rd, 8'h33);

    // Read-only register write
    wr_txn(8'h42, 8'h0A, 1, 8'h00, 8'h00, 8'h00, 1'b1);
    wr_txn(8'h42, 8'h0A, 0, 8'h00, 8'h00, 8'h00, 1'b1);
    rd_txn(1, last_rd);
    chk("pid_lit", last_rd, 8'h76);

    // Reset during bit 5 of a read byte
    wr_txn(8'h42, 8'h0A, 0, 8'h00, 8'h00, 8'h00, 1'b1);
    bus_start();
    send_byte(8'h43, a);
    chk("rst_rd_dev_ack", a, 1'b1);
    for (int i = 0; i < 4; i++) begin
      waitc(H); m_scl = 1'b1;
      waitc(H); m_scl = 1'b0;
    end
    waitc(H/2);
    cur = m_mem[m_ptr];
    exp_oe = !cur[3];
    chk("oe_bit5_before_reset", bus.sio_d_oe, exp_oe);
    rst_n = 1'b0;
    #1;
    chk("oe_after_reset", bus.sio_d_oe, 1'b0);
    chk("busy_after_reset", bus.busy, 1'b0);
    m_reset();
    waitc(3);
    rst_n = 1'b1;
    m_sda = 1'b1;
    waitc(H);
    wr_txn(8'h42, 8'h40, 1, 8'hD0, 8'h00, 8'h00, 1'b1);
    chk("post_rst_wr_addr_lit", bus.wr_addr, 8'h40);
    chk("post_rst_wr_data_lit", bus.wr_data, 8'hD0);
    wr_txn(8'h42, 8'h40, 0, 8'h00, 8'h00, 8'h00, 1'b0);
    rd_txn(1, last_rd);
    chk("post_rst_rd_lit", last_rd, 8'hD0);
    wr_txn(8'h42, 8'h12, 0, 8'h00, 8'h00, 8'h00, 1'b1);
    rd_txn(1, last_rd);
    chk("reg12_reset_lit", last_rd, 8'h00);

    waitc(10);
    chk("commit_count", commits_seen, commits_exp);
    chk("commit_queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
